// File: rtl/dft_frame_feeder.sv
// Purpose: gathers audio samples into FRAME_LEN ping-pong banks and streams each full bank to the DFT core, two samples per cycle.
// Latency: next pulses two cycles after the last sample of a frame; data follows next directly for FRAME_LEN/2 cycles.
// Backpressure: a frame waits in its bank until dft_ready; samples arriving while the write bank is full are dropped and flag overflow.
module dft_frame_feeder #(
   parameter int FRAME_LEN = 512,
   parameter int SAMPLE_W  = 12,
   parameter int OUT_W     = 16,
   parameter int CNT_W     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   input  logic                dft_ready,
   output logic                next,
   output logic [OUT_W-1:0]    x0,
   output logic [OUT_W-1:0]    x1,
   output logic [OUT_W-1:0]    x2,
   output logic [OUT_W-1:0]    x3,
   output logic                streaming,
   output logic                overflow,
   output logic [CNT_W-1:0]    frames_sent
);

   localparam int AW   = $clog2(FRAME_LEN);
   localparam int HALF = FRAME_LEN / 2;

   typedef enum logic [1:0] {IDLE, START, STREAM, DONE} state_t;

   state_t              state;
   logic [1:0]          full;
   logic                wr_bank;
   logic                rd_bank;
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_idx;
   logic [SAMPLE_W-1:0] mem [0:2*FRAME_LEN-1];

   logic                in_done;
   logic                wr_free;
   logic                wr_take;
   logic [AW:0]         rd_addr_even;
   logic [AW:0]         rd_addr_odd;

   function automatic logic [OUT_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
      return {{(OUT_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
   endfunction

   // Imaginary parts are always zero for real audio input.
   assign x1 = '0;
   assign x3 = '0;

   // Write-bank availability; a bank freed in DONE accepts a sample in that same cycle.
   always_comb begin
      in_done      = (state == DONE);
      wr_free      = !full[wr_bank] || (in_done && (rd_bank == wr_bank));
      wr_take      = sample_valid && wr_free;
      rd_addr_even = {rd_bank, rd_idx[AW-2:0], 1'b0};
      rd_addr_odd  = {rd_bank, rd_idx[AW-2:0], 1'b1};
   end

   // Sample storage: both banks in one array, bank number as the address MSB.
   always_ff @(posedge clk) begin
      if (wr_take && !reset)
         mem[{wr_bank, wr_ptr}] <= sample_in;
   end

   // Write pointer, bank toggling, full flags and the sticky overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         full     <= '0;
         wr_bank  <= 1'b0;
         wr_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         // The read side never clears the bank the write side is completing, so both updates can coexist.
         if (in_done)
            full[rd_bank] <= 1'b0;
         if (wr_take) begin
            if (wr_ptr == AW'(FRAME_LEN-1)) begin
               full[wr_bank] <= 1'b1;
               wr_ptr        <= '0;
               wr_bank       <= ~wr_bank;
            end else begin
               wr_ptr <= wr_ptr + 1'b1;
            end
         end else if (sample_valid) begin
            overflow <= 1'b1;
         end
      end
   end

   // Read sequencer: waits for the oldest full bank, pulses next, then streams one sample pair per cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rd_bank     <= 1'b0;
         rd_idx      <= '0;
         next        <= 1'b0;
         streaming   <= 1'b0;
         x0          <= '0;
         x2          <= '0;
         frames_sent <= '0;
      end else begin
         case (state)
            IDLE: begin
               rd_idx <= '0;
               if (full[rd_bank] && dft_ready) begin
                  next  <= 1'b1;
                  state <= START;
               end
            end
            START: begin
               // Pair 0 is loaded here so it is visible in the cycle right after next.
               next      <= 1'b0;
               streaming <= 1'b1;
               x0        <= sext(mem[rd_addr_even]);
               x2        <= sext(mem[rd_addr_odd]);
               rd_idx    <= rd_idx + 1'b1;
               state     <= STREAM;
            end
            STREAM: begin
               if (rd_idx == AW'(HALF)) begin
                  streaming <= 1'b0;
                  x0        <= '0;
                  x2        <= '0;
                  rd_idx    <= '0;
                  state     <= DONE;
               end else begin
                  x0     <= sext(mem[rd_addr_even]);
                  x2     <= sext(mem[rd_addr_odd]);
                  rd_idx <= rd_idx + 1'b1;
               end
            end
            DONE: begin
               // The idle check is folded in here so a queued frame starts two cycles after the last data cycle.
               frames_sent <= frames_sent + 1'b1;
               rd_bank     <= ~rd_bank;
               if (full[~rd_bank] && dft_ready) begin
                  next  <= 1'b1;
                  state <= START;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dft_frame_feeder.sv
module tb_dft_frame_feeder;

   localparam int FL = 8;
   localparam int SW = 12;
   localparam int OW = 16;
   localparam int CW = 2;

   typedef logic [SW-1:0] smp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [SW-1:0] sample_in;
   logic          sample_valid;
   logic          dft_ready;
   logic          next;
   logic [OW-1:0] x0, x1, x2, x3;
   logic          streaming;
   logic          overflow;
   logic [CW-1:0] frames_sent;

   always #5 clk = ~clk;

   dft_frame_feeder #(.FRAME_LEN(FL), .SAMPLE_W(SW), .OUT_W(OW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
      .dft_ready(dft_ready), .next(next), .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .streaming(streaming), .overflow(overflow), .frames_sent(frames_sent)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: accepted samples, completed frames in order, banks occupied.
   smp_t    exp_q[$];
   smp_t    partial[$];
   int      pending = 0;
   bit      release_flag = 0;
   bit      ovf_model = 0;
   bit      ovf_pending = 0;
   logic [CW-1:0] sent_cnt = '0;
   int      mon_state = 0;
   int      mon_k = 0;
   bit      mon_en = 0;
   bit      prev_ready = 0;
   smp_t    cur[FL];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic logic [OW-1:0] ext(input smp_t s);
      int v;
      v = $signed(s);
      return v[OW-1:0];
   endfunction

   // One cycle of stimulus, issued 1 time unit after the rising edge.
   task automatic drive_cycle(input bit v, input smp_t d);
      if (release_flag) begin
         pending--;
         release_flag = 0;
      end
      if (v) begin
         if (pending < 2) begin
            partial.push_back(d);
            if (partial.size() == FL) begin
               foreach (partial[i]) exp_q.push_back(partial[i]);
               partial.delete();
               pending++;
            end
         end else begin
            ovf_pending = 1;
         end
      end
      sample_valid = v;
      sample_in    = d;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic reset_cycle();
      reset        = 1'b1;
      sample_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      partial.delete();
      exp_q.delete();
      pending      = 0;
      release_flag = 0;
      ovf_pending  = 0;
   endtask

   task automatic wait_next(input string name);
      int n = 0;
      while (!next && n < 100) begin
         drive_cycle(1'b0, '0);
         n++;
      end
      check({name, "_next_timeout"}, next, 1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      dft_ready = 1'b1;
      while ((exp_q.size() != 0 || mon_state != 0) && n < 300) begin
         drive_cycle(1'b0, '0);
         n++;
      end
      check({name, "_drain_timeout"}, (exp_q.size() == 0 && mon_state == 0), 1);
   endtask

   // Monitor/scoreboard: compares every cycle against the model, away from the active edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("overflow", overflow, ovf_model);
         ovf_model   = ovf_model | ovf_pending;
         ovf_pending = 0;
         check("frames_sent", frames_sent, sent_cnt);
         check("x1_zero", x1, 0);
         check("x3_zero", x3, 0);
         case (mon_state)
            0: begin
               check("idle_streaming", streaming, 0);
               check("idle_x0", x0, 0);
               check("idle_x2", x2, 0);
               if (next) begin
                  check("next_without_ready", prev_ready, 1);
                  check("next_without_frame", exp_q.size() >= FL, 1);
                  for (int i = 0; i < FL; i++)
                     cur[i] = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                  mon_state = 1;
                  mon_k     = 0;
               end
            end
            1: begin
               check("stream_next", next, 0);
               check("stream_streaming", streaming, 1);
               check("stream_x0", x0, ext(cur[2*mon_k]));
               check("stream_x2", x2, ext(cur[2*mon_k+1]));
               mon_k++;
               if (mon_k == FL/2) begin
                  mon_state    = 2;
                  release_flag = 1;
               end
            end
            default: begin
               check("done_next", next, 0);
               check("done_streaming", streaming, 0);
               check("done_x0", x0, 0);
               sent_cnt  = sent_cnt + 1'b1;
               mon_state = 0;
            end
         endcase
         if (reset) begin
            mon_state    = 0;
            sent_cnt     = '0;
            ovf_model    = 0;
            ovf_pending  = 0;
            release_flag = 0;
         end
      end
      prev_ready = dft_ready;
   end

   initial begin
      smp_t p2s[FL];
      logic [CW-1:0] seq[5];
      p2s = '{12'h800, 12'h7FF, 12'h123, 12'hFFF, 12'h000, 12'h001, 12'h7FE, 12'h801};
      seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      reset        = 1'b1;
      sample_valid = 1'b0;
      sample_in    = '0;
      dft_ready    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset  = 1'b0;
      mon_en = 1;
      check("rst_next", next, 0);
      check("rst_streaming", streaming, 0);
      check("rst_x0", x0, 0);
      check("rst_x2", x2, 0);
      check("rst_overflow", overflow, 0);
      check("rst_frames_sent", frames_sent, 0);

      // Basic frame, one sample every 4 cycles.
      dft_ready = 1'b1;
      for (int i = 1; i <= FL; i++) begin
         drive_cycle(1'b1, smp_t'(i));
         repeat (3) drive_cycle(1'b0, '0);
      end
      drain("p1");
      check("p1_frames_sent", frames_sent, 1);

      // Sign extension of extreme values.
      for (int i = 0; i < FL; i++) drive_cycle(1'b1, p2s[i]);
      wait_next("p2");
      drive_cycle(1'b0, '0);
      check("p2_sext_neg", x0, 16'hF800);
      check("p2_sext_pos", x2, 16'h07FF);
      drain("p2");

      // Both banks fill under backpressure; the 17th sample is dropped.
      dft_ready = 1'b0;
      for (int i = 0; i < 2*FL + 1; i++) drive_cycle(1'b1, smp_t'($urandom));
      drive_cycle(1'b0, '0);
      check("p3_overflow_set", overflow, 1);
      check("p3_no_next", next, 0);
      drain("p3");

      // Sample arriving in the DONE cycle of bank 0 while bank 1 is full.
      reset_cycle();
      dft_ready = 1'b0;
      for (int i = 0; i < 2*FL; i++) drive_cycle(1'b1, smp_t'($urandom));
      dft_ready = 1'b1;
      wait_next("p4");
      repeat (1 + FL/2) drive_cycle(1'b0, '0);
      drive_cycle(1'b1, 12'h5A5);
      check("p4_no_overflow", overflow, 0);
      for (int i = 1; i < FL; i++) drive_cycle(1'b1, smp_t'($urandom));
      drain("p4");

      // Reset in the second data cycle aborts the frame.
      for (int i = 0; i < FL; i++) drive_cycle(1'b1, smp_t'($urandom));
      wait_next("p5");
      drive_cycle(1'b0, '0);
      drive_cycle(1'b0, '0);
      reset_cycle();
      check("p5_next", next, 0);
      check("p5_streaming", streaming, 0);
      check("p5_x0", x0, 0);
      check("p5_x2", x2, 0);
      check("p5_frames_sent", frames_sent, 0);
      for (int i = 0; i < FL; i++) drive_cycle(1'b1, smp_t'($urandom));
      drain("p5");
      check("p5_frames_after", frames_sent, 1);

      // frames_sent wraps modulo 4.
      reset_cycle();
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < FL; i++) drive_cycle(1'b1, smp_t'($urandom));
         drain("p6");
         check("p6_wrap", frames_sent, seq[f]);
      end

      // Random traffic with random backpressure.
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 15) == 0) dft_ready = ~dft_ready;
         drive_cycle($urandom_range(0, 2) == 0, smp_t'($urandom));
      end
      drain("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
